// File: rtl/intf_pkg.sv
// Shared definitions for the line-to-frame demultiplexer: framing state
// encoding, error counter width and legal DEMUX range.
package intf_pkg;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;

    typedef enum logic [1:0] {
        S_HUNT = ST_HUNT,
        S_PRE  = ST_PRE,
        S_SYNC = ST_SYNC
    } state_e;

    localparam int ERRW      = 16;
    localparam int DEMUX_MIN = 2;
    localparam int DEMUX_MAX = 16;

endpackage

// File: rtl/intf_demux_sync_if.sv
// Receive-side bus of the demultiplexer: line words in, assembled frames out.
// ovld is a one-cycle strobe with no backpressure: odat is valid only in the cycle ovld is high.
interface intf_demux_sync_if #(
    parameter int LINEBIT = 12,
    parameter int DEMUX   = 6
);

    localparam int DATABIT = DEMUX * LINEBIT;

    logic [LINEBIT-1:0]          idat;
    logic                        isyn;
    logic                        iclrerr;
    logic [DATABIT-1:0]          odat;
    logic                        ovld;
    logic                        olock;
    logic                        oslip;
    logic [intf_pkg::ERRW-1:0]   oerrcnt;

    modport master (
        output idat, isyn, iclrerr,
        input  odat, ovld, olock, oslip, oerrcnt
    );

    modport slave (
        input  idat, isyn, iclrerr,
        output odat, ovld, olock, oslip, oerrcnt
    );

endinterface

// File: rtl/intf_sync_fsm.sv
// Framing state machine: hunt/presync/sync with a flywheel, slip detection
// and a saturating sync error counter.
module intf_sync_fsm
    import intf_pkg::*;
#(
    parameter int CNTW    = 4,
    parameter int LOCKCNT = 2,
    parameter int LOSSCNT = 3
) (
    input  logic            iclk,
    input  logic            rst,
    input  logic            isyn_i,
    input  logic [CNTW-1:0] cntph_i,
    input  logic            iclrerr_i,
    output state_e          state_o,
    output logic            lock_o,
    output logic            slip_o,
    output logic [ERRW-1:0] errcnt_o
);

    localparam logic [2:0] LOCK_N = 3'(LOCKCNT);
    localparam logic [2:0] LOSS_N = 3'(LOSSCNT);

    state_e          state_q;
    logic [2:0]      good_q;
    logic [2:0]      bad_q;
    logic            lock_q;
    logic            slip_q;
    logic [ERRW-1:0] errcnt_q;

    logic boundary, good_syn, miss_syn, mis_syn, err_evt;

    always_comb begin
        boundary = (cntph_i == '0);
        good_syn = isyn_i && boundary;
        miss_syn = !isyn_i && boundary;
        mis_syn  = isyn_i && !boundary;
        err_evt  = (state_q == S_SYNC) && (miss_syn || mis_syn);
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HUNT;
            good_q   <= '0;
            bad_q    <= '0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            slip_q <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    if (isyn_i) begin
                        good_q <= 3'd1;
                        bad_q  <= '0;
                        if (LOCKCNT == 1) begin
                            state_q <= S_SYNC;
                            lock_q  <= 1'b1;
                        end else begin
                            state_q <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (good_syn) begin
                        good_q <= good_q + 3'd1;
                        if (good_q + 3'd1 == LOCK_N) begin
                            state_q <= S_SYNC;
                            lock_q  <= 1'b1;
                            bad_q   <= '0;
                        end
                    end else if (mis_syn) begin
                        good_q <= 3'd1;
                        slip_q <= 1'b1;
                    end else if (miss_syn) begin
                        state_q <= S_HUNT;
                        good_q  <= '0;
                    end
                end
                S_SYNC: begin
                    if (good_syn) begin
                        bad_q <= '0;
                    end else if (miss_syn || mis_syn) begin
                        slip_q <= mis_syn;
                        // Flywheel: only LOSSCNT consecutive bad boundaries drop the lock.
                        if (bad_q + 3'd1 == LOSS_N) begin
                            state_q <= S_HUNT;
                            lock_q  <= 1'b0;
                            bad_q   <= '0;
                            good_q  <= '0;
                        end else begin
                            bad_q <= bad_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                    lock_q  <= 1'b0;
                end
            endcase

            if (iclrerr_i) begin
                errcnt_q <= '0;
            end else if (err_evt && (errcnt_q != '1)) begin
                errcnt_q <= errcnt_q + ERRW'(1);
            end
        end
    end

    assign state_o  = state_q;
    assign lock_o   = lock_q;
    assign slip_o   = slip_q;
    assign errcnt_o = errcnt_q;

endmodule

// File: rtl/intf_demux_sync.sv
// Line-to-parallel demultiplexer: gathers DEMUX line words into one frame,
// aligned by the sync strobe and gated by the framing state machine.
module intf_demux_sync
    import intf_pkg::*;
#(
    parameter int LINEBIT = 12,
    parameter int DEMUX   = 6,
    parameter int CNTW    = 4,
    parameter int LOCKCNT = 2,
    parameter int LOSSCNT = 3,
    parameter int ORDER   = 0,
    parameter int DATABIT = DEMUX * LINEBIT
) (
    input logic              iclk,
    input logic              rst,
    intf_demux_sync_if.slave bus
);

    localparam logic [CNTW-1:0] PH_LAST = CNTW'(DEMUX - 1);

    logic [CNTW-1:0]            cntph_q, cntph_d;
    logic [DATABIT-LINEBIT-1:0] shf_q;
    logic [DATABIT-1:0]         dacap, frame_w, odat_q;
    logic                       ovld_q, latch_en;

    state_e          fsm_state;
    logic            fsm_lock, fsm_slip;
    logic [ERRW-1:0] fsm_errcnt;

    always_comb begin
        cntph_d = cntph_q + CNTW'(1);
        if (bus.isyn) begin
            cntph_d = CNTW'(1);
        end else if (cntph_q == PH_LAST) begin
            cntph_d = '0;
        end
    end

    // Oldest word sits in the MSBs, the word arriving this cycle in the LSBs.
    assign dacap = {shf_q, bus.idat};

    always_comb begin
        frame_w = dacap;
        if (ORDER != 0) begin
            for (int k = 0; k < DEMUX; k++) begin
                frame_w[k*LINEBIT +: LINEBIT] = dacap[(DEMUX-1-k)*LINEBIT +: LINEBIT];
            end
        end
    end

    // A sync on the last phase cuts the frame short, so it never latches.
    assign latch_en = (fsm_state == S_SYNC) && (cntph_q == PH_LAST) && !bus.isyn;

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            cntph_q <= '0;
            shf_q   <= '0;
            odat_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            cntph_q <= cntph_d;
            shf_q   <= dacap[DATABIT-LINEBIT-1:0];
            ovld_q  <= latch_en;
            if (latch_en) begin
                odat_q <= frame_w;
            end
        end
    end

    intf_sync_fsm #(
        .CNTW    (CNTW),
        .LOCKCNT (LOCKCNT),
        .LOSSCNT (LOSSCNT)
    ) u_fsm (
        .iclk      (iclk),
        .rst       (rst),
        .isyn_i    (bus.isyn),
        .cntph_i   (cntph_q),
        .iclrerr_i (bus.iclrerr),
        .state_o   (fsm_state),
        .lock_o    (fsm_lock),
        .slip_o    (fsm_slip),
        .errcnt_o  (fsm_errcnt)
    );

    assign bus.odat    = odat_q;
    assign bus.ovld    = ovld_q;
    assign bus.olock   = fsm_lock;
    assign bus.oslip   = fsm_slip;
    assign bus.oerrcnt = fsm_errcnt;

endmodule

// File: tb/tb_intf_demux_sync.sv
// Directed bench for intf_demux_sync: ORDER=0 and ORDER=1 instances share
// stimulus; a DEMUX=2 instance exercises error counter saturation.
module tb_intf_demux_sync;

    logic iclk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vld_seen;

    always #5 iclk = ~iclk;

    intf_demux_sync_if #(.LINEBIT(12), .DEMUX(6)) if0 ();
    intf_demux_sync_if #(.LINEBIT(12), .DEMUX(6)) if1 ();
    intf_demux_sync_if #(.LINEBIT(4),  .DEMUX(2)) if2 ();

    assign if1.idat    = if0.idat;
    assign if1.isyn    = if0.isyn;
    assign if1.iclrerr = if0.iclrerr;

    intf_demux_sync #(.LINEBIT(12), .DEMUX(6), .CNTW(4), .LOCKCNT(2), .LOSSCNT(3), .ORDER(0))
        u_dut (.iclk(iclk), .rst(rst), .bus(if0));
    intf_demux_sync #(.LINEBIT(12), .DEMUX(6), .CNTW(4), .LOCKCNT(2), .LOSSCNT(3), .ORDER(1))
        u_ord1 (.iclk(iclk), .rst(rst), .bus(if1));
    intf_demux_sync #(.LINEBIT(4), .DEMUX(2), .CNTW(2), .LOCKCNT(1), .LOSSCNT(7), .ORDER(0))
        u_sat (.iclk(iclk), .rst(rst), .bus(if2));

    task automatic step(input logic syn, input logic [11:0] dat, input logic clr);
        if0.isyn    = syn;
        if0.idat    = dat;
        if0.iclrerr = clr;
        @(posedge iclk);
        #1;
        if (if0.ovld === 1'b1) vld_seen++;
    endtask

    task automatic frame(input logic syn, input logic [11:0] w0, input logic [11:0] inc);
        logic [11:0] w;
        w = w0;
        for (int k = 0; k < 6; k++) begin
            step(syn && (k == 0), w, 1'b0);
            w = w + inc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.isyn = 1'b0; if0.idat = '0; if0.iclrerr = 1'b0;
        if2.isyn = 1'b0; if2.idat = '0; if2.iclrerr = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        n_tests++; if (if0.odat !== 72'h0) begin n_fail++; $display("FAIL reset_odat: got %h want 0", if0.odat); end
        n_tests++; if (if0.ovld !== 1'b0) begin n_fail++; $display("FAIL reset_ovld: got %b want 0", if0.ovld); end
        n_tests++; if (if0.olock !== 1'b0) begin n_fail++; $display("FAIL reset_olock: got %b want 0", if0.olock); end
        n_tests++; if (if0.oslip !== 1'b0) begin n_fail++; $display("FAIL reset_oslip: got %b want 0", if0.oslip); end
        n_tests++; if (if0.oerrcnt !== 16'h0) begin n_fail++; $display("FAIL reset_oerrcnt: got %h want 0", if0.oerrcnt); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        vld_seen = 0;
        frame(1'b1, 12'h001, 12'h001);
        n_tests++; if (if0.olock !== 1'b0) begin n_fail++; $display("FAIL lock_early: olock=%b want 0", if0.olock); end
        n_tests++; if (vld_seen != 0) begin n_fail++; $display("FAIL lock_vld_early: ovld pulses=%0d want 0", vld_seen); end
        step(1'b1, 12'h001, 1'b0);
        n_tests++; if (if0.olock !== 1'b1) begin n_fail++; $display("FAIL lock_rise: olock=%b want 1", if0.olock); end
        for (int w = 2; w <= 6; w++) step(1'b0, 12'(w), 1'b0);
        n_tests++; if (if0.ovld !== 1'b1 || vld_seen != 1) begin n_fail++; $display("FAIL lock_first_vld: ovld=%b pulses=%0d want 1/1", if0.ovld, vld_seen); end
        n_tests++; if (if0.odat !== 72'h001002003004005006) begin n_fail++; $display("FAIL lock_odat_order0: got %h want 001002003004005006", if0.odat); end
        n_tests++; if (if1.odat !== 72'h006005004003002001) begin n_fail++; $display("FAIL lock_odat_order1: got %h want 006005004003002001", if1.odat); end
    endtask

    task automatic test_steady();
        logic [11:0] wv [6];
        wv = '{12'hFFF, 12'h000, 12'h5A5, 12'hA5A, 12'h800, 12'h001};
        vld_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step(k == 0, wv[k], 1'b0);
            if (k == 0) begin
                n_tests++; if (if0.ovld !== 1'b0) begin n_fail++; $display("FAIL vld_pulse_width: ovld=%b want 0", if0.ovld); end
            end
        end
        n_tests++; if (vld_seen != 1) begin n_fail++; $display("FAIL steady_vld: pulses=%0d want 1", vld_seen); end
        n_tests++; if (if0.odat !== 72'hFFF0005A5A5A800001) begin n_fail++; $display("FAIL steady_odat_order0: got %h want FFF0005A5A5A800001", if0.odat); end
        n_tests++; if (if1.odat !== 72'h001800A5A5A5000FFF) begin n_fail++; $display("FAIL steady_odat_order1: got %h want 001800A5A5A5000FFF", if1.odat); end
        n_tests++; if (if0.oerrcnt !== 16'h0) begin n_fail++; $display("FAIL steady_err: got %h want 0", if0.oerrcnt); end
    endtask

    task automatic test_slip();
        vld_seen = 0;
        step(1'b1, 12'h111, 1'b0);
        step(1'b0, 12'h222, 1'b0);
        step(1'b0, 12'h333, 1'b0);
        step(1'b1, 12'h010, 1'b0);
        n_tests++; if (if0.oslip !== 1'b1) begin n_fail++; $display("FAIL slip_pulse: oslip=%b want 1", if0.oslip); end
        n_tests++; if (if0.oerrcnt !== 16'd1) begin n_fail++; $display("FAIL slip_err: got %0d want 1", if0.oerrcnt); end
        n_tests++; if (if0.olock !== 1'b1) begin n_fail++; $display("FAIL slip_lock: olock=%b want 1", if0.olock); end
        step(1'b0, 12'h020, 1'b0);
        n_tests++; if (if0.oslip !== 1'b0) begin n_fail++; $display("FAIL slip_width: oslip=%b want 0", if0.oslip); end
        step(1'b0, 12'h030, 1'b0);
        step(1'b0, 12'h040, 1'b0);
        step(1'b0, 12'h050, 1'b0);
        n_tests++; if (vld_seen != 0) begin n_fail++; $display("FAIL slip_partial: pulses=%0d want 0", vld_seen); end
        step(1'b0, 12'h060, 1'b0);
        n_tests++; if (if0.ovld !== 1'b1) begin n_fail++; $display("FAIL slip_realign_vld: ovld=%b want 1", if0.ovld); end
        n_tests++; if (if0.odat !== 72'h010020030040050060) begin n_fail++; $display("FAIL slip_realign_odat: got %h want 010020030040050060", if0.odat); end
    endtask

    task automatic test_clr_collision();
        frame(1'b1, 12'h100, 12'h001);
        n_tests++; if (if0.oerrcnt !== 16'd1) begin n_fail++; $display("FAIL clr_pre_err: got %0d want 1", if0.oerrcnt); end
        step(1'b1, 12'h200, 1'b0);
        step(1'b0, 12'h201, 1'b0);
        step(1'b1, 12'h300, 1'b1);
        n_tests++; if (if0.oslip !== 1'b1) begin n_fail++; $display("FAIL clr_slip: oslip=%b want 1", if0.oslip); end
        n_tests++; if (if0.oerrcnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d want 0", if0.oerrcnt); end
        for (int w = 1; w < 6; w++) step(1'b0, 12'h300 + 12'(w), 1'b0);
        n_tests++; if (if0.odat !== 72'h300301302303304305) begin n_fail++; $display("FAIL clr_frame_odat: got %h want 300301302303304305", if0.odat); end
        frame(1'b1, 12'h400, 12'h001);
        n_tests++; if (if0.oerrcnt !== 16'd0 || if0.olock !== 1'b1) begin n_fail++; $display("FAIL clr_after: err=%0d lock=%b want 0/1", if0.oerrcnt, if0.olock); end
    endtask

    task automatic test_loss();
        vld_seen = 0;
        frame(1'b0, 12'h500, 12'h001);
        n_tests++; if (vld_seen != 1 || if0.oerrcnt !== 16'd1 || if0.olock !== 1'b1) begin n_fail++; $display("FAIL loss_fly1: pulses=%0d err=%0d lock=%b want 1/1/1", vld_seen, if0.oerrcnt, if0.olock); end
        n_tests++; if (if0.odat !== 72'h500501502503504505) begin n_fail++; $display("FAIL loss_fly1_odat: got %h want 500501502503504505", if0.odat); end
        frame(1'b0, 12'h600, 12'h001);
        n_tests++; if (vld_seen != 2 || if0.oerrcnt !== 16'd2) begin n_fail++; $display("FAIL loss_fly2: pulses=%0d err=%0d want 2/2", vld_seen, if0.oerrcnt); end
        step(1'b0, 12'h700, 1'b0);
        n_tests++; if (if0.olock !== 1'b0) begin n_fail++; $display("FAIL loss_drop: olock=%b want 0", if0.olock); end
        n_tests++; if (if0.oerrcnt !== 16'd3) begin n_fail++; $display("FAIL loss_err: got %0d want 3", if0.oerrcnt); end
        for (int w = 1; w < 6; w++) step(1'b0, 12'h700 + 12'(w), 1'b0);
        frame(1'b0, 12'h800, 12'h001);
        n_tests++; if (vld_seen != 2 || if0.oerrcnt !== 16'd3) begin n_fail++; $display("FAIL loss_hunt: pulses=%0d err=%0d want 2/3", vld_seen, if0.oerrcnt); end
        n_tests++; if (if0.odat !== 72'h600601602603604605) begin n_fail++; $display("FAIL loss_hold_odat: got %h want 600601602603604605", if0.odat); end
    endtask

    task automatic test_reset_midstream();
        frame(1'b1, 12'h900, 12'h001);
        frame(1'b1, 12'hA00, 12'h001);
        n_tests++; if (if0.ovld !== 1'b1 || if0.olock !== 1'b1) begin n_fail++; $display("FAIL mid_pre: ovld=%b lock=%b want 1/1", if0.ovld, if0.olock); end
        rst = 1'b1;
        #1;
        n_tests++; if (if0.odat !== 72'h0 || if1.odat !== 72'h0) begin n_fail++; $display("FAIL mid_odat: got %h/%h want 0", if0.odat, if1.odat); end
        n_tests++; if (if0.ovld !== 1'b0 || if0.olock !== 1'b0 || if0.oslip !== 1'b0) begin n_fail++; $display("FAIL mid_flags: vld=%b lock=%b slip=%b want 0", if0.ovld, if0.olock, if0.oslip); end
        n_tests++; if (if0.oerrcnt !== 16'h0) begin n_fail++; $display("FAIL mid_err: got %0d want 0", if0.oerrcnt); end
        @(posedge iclk);
        #1;
        rst = 1'b0;
        vld_seen = 0;
        frame(1'b1, 12'hB00, 12'h001);
        n_tests++; if (vld_seen != 0 || if0.olock !== 1'b0) begin n_fail++; $display("FAIL mid_relock1: pulses=%0d lock=%b want 0/0", vld_seen, if0.olock); end
        frame(1'b1, 12'hC00, 12'h001);
        n_tests++; if (vld_seen != 1 || if0.odat !== 72'hC00C01C02C03C04C05) begin n_fail++; $display("FAIL mid_relock2: pulses=%0d odat=%h want 1/C00C01C02C03C04C05", vld_seen, if0.odat); end
    endtask

    task automatic test_saturation();
        if2.isyn = 1'b1;
        repeat (800) @(posedge iclk);
        #1;
        n_tests++; if (if2.oerrcnt !== 16'd700) begin n_fail++; $display("FAIL sat_count: got %0d want 700", if2.oerrcnt); end
        n_tests++; if (if2.olock !== 1'b0) begin n_fail++; $display("FAIL sat_lock_phase: olock=%b want 0", if2.olock); end
        repeat (74200) @(posedge iclk);
        #1;
        n_tests++; if (if2.oerrcnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want FFFF", if2.oerrcnt); end
        repeat (16) @(posedge iclk);
        #1;
        n_tests++; if (if2.oerrcnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want FFFF", if2.oerrcnt); end
        if2.isyn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_steady();
        test_slip();
        test_clr_collision();
        test_loss();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intf_demux_sync.md
Name: intf_demux_sync

Overview:
- Parametrised line-to-parallel demultiplexer for FPGA interface integration.
- Gathers DEMUX consecutive LINEBIT words from a fast-clock interface into one DATABIT word. Alignment comes from a sync strobe.
- Adds to the basic demux:
  - a hunt/presync/sync framing state machine with a flywheel,
  - slip and loss detection with a saturating error counter,
  - selectable word ordering and an output valid strobe.
- Sits on the receive side of the FPGA-to-FPGA link, ahead of channel deframing.

Parameters:
- LINEBIT, 12, bits per received line word.
- DEMUX, 6, words per frame; legal 2..16.
- CNTW, 4, phase counter width; must satisfy DEMUX <= 2**CNTW.
- LOCKCNT, 2, consecutive aligned syncs needed to enter SYNC; legal 1..7.
- LOSSCNT, 3, consecutive bad frame boundaries in SYNC needed to drop to HUNT; legal 1..7.
- ORDER, 0, word order: 0 puts the first word (phase 0) in the MSBs; 1 puts phase 0 in the LSBs.
- DATABIT, DEMUX*LINEBIT, derived; do not override.

Ports:
- iclk  in  1  line clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- idat  in  LINEBIT  received line word.
- isyn  in  1  sync strobe; high with the phase-0 word.
- iclrerr  in  1  synchronous clear of oerrcnt.
- odat  out  DATABIT  assembled frame.
- ovld  out  1  one-cycle pulse; odat updated this cycle.
- olock  out  1  high while in SYNC.
- oslip  out  1  one-cycle pulse on a misplaced sync.
- oerrcnt  out  16  saturating count of sync errors.

Behaviour:
- Reset:
  - One clock, iclk. Reset rst is asynchronous and active-high.
  - On reset, odat, shift register, cntph, all counters and all outputs go to 0, and the state goes to HUNT.
  - Reset asserted mid-frame clears these immediately. After release the block hunts again.
- Phase counter cntph:
  - isyn: load 1.
  - Otherwise: increment, and wrap from DEMUX-1 to 0.
  - The counter free-runs in every state.
- Shift register:
  - Every cycle: shf <= {shf, idat}[DATABIT-1:0].
  - dacap = {shf, idat} (low DATABIT bits) holds the last DEMUX words, with the current word in the LSBs.
- Event definitions:
  - Frame boundary: a cycle with cntph == 0 (the counter is at the wrap point).
  - Good sync: isyn at a boundary.
  - Missing sync: a boundary without isyn.
  - Misplaced sync: isyn with cntph != 0.
- Framing FSM:
  - HUNT:
    - Any isyn moves to PRESYNC with good=1.
    - If LOCKCNT==1, go directly to SYNC.
  - PRESYNC:
    - Good sync: good++. When good reaches LOCKCNT, go to SYNC.
    - Misplaced sync: good=1, stay in PRESYNC, pulse oslip.
    - Missing sync: go to HUNT.
  - SYNC:
    - Good sync: bad=0.
    - Missing sync (flywheel): bad++, oerrcnt++.
    - Misplaced sync: bad++, oerrcnt++, pulse oslip. The counter realigns through the isyn load.
    - When bad reaches LOSSCNT, go to HUNT and clear bad.
- Latching:
  - In a cycle with cntph == DEMUX-1 and state SYNC (registered state), odat <= dacap, with words reordered when ORDER=1.
  - ovld is registered high for that same update, so it is visible with the new odat.
  - Latency: odat/ovld update on the same edge that samples the phase DEMUX-1 word.
  - Partial frames cut short by a misplaced sync are never latched.
  - odat holds its value when not in SYNC.
- oerrcnt:
  - Saturates at 16'hFFFF.
  - iclrerr wins over a simultaneous increment, so the result is 0.
- oslip and ovld are high for exactly one cycle per event.
- olock equals (state == SYNC), registered.

Decomposition:
- Shared package intf_pkg holds:
  - state encoding localparams (ST_HUNT=2'd0, ST_PRE=2'd1, ST_SYNC=2'd2),
  - the error counter width (16),
  - the DEMUX legality limits.
- One natural sub-module: intf_sync_fsm. It owns the framing FSM, good/bad counters, slip detection and the error counter. Its inputs are isyn and cntph; its outputs are state, oslip and oerrcnt.
- Datapath (counter, shift, latch) stays in the top.

Test Plan:
- Reset: assert rst mid-stream -> odat=0, ovld=0, olock=0, oslip=0, oerrcnt=0 at once. After release, no ovld until lock.
- Lock, ORDER=0, DEMUX=6, LINEBIT=12, LOCKCNT=2:
  - Stimulus: isyn every 6 cycles, with idat 0x001..0x006 each frame.
  - olock rises after the 2nd isyn.
  - The first ovld falls on the 6th word of the 2nd frame, with odat=72'h001002003004005006.
- ORDER=1, same stimulus -> odat=72'h006005004003002001.
- Slip: in SYNC, isyn at phase 3 -> oslip pulses once, oerrcnt=1, olock stays 1, no ovld for the partial frame. The next ovld comes 6 cycles after the new sync.
- Loss, LOSSCNT=3: stop isyn while locked.
  - ovld continues for 2 flywheel frames.
  - oerrcnt=3.
  - olock falls after the 3rd missing boundary, and ovld stops.
- Counter: force 0xFFFF errors -> oerrcnt holds 0xFFFF. Assert iclrerr in the same cycle as an error -> oerrcnt=0.
